maj_fold_ctrl: RTL and testbench

//  Sequential (folded) majority/threshold evaluator for wide vectors.
//  - Accepts an N-bit vector via valid/ready and scores it CHUNK bits per cycle.
//  - Each cycle one shared popcount slice adds a chunk into an accumulator.
//  - The final count is compared against THRESH, so a wide combinational majority

---
 rtl/maj_fold_pkg.sv | 26 ++
 rtl/maj_fold_ctrl_popcount.sv | 17 +
 rtl/maj_fold_ctrl.sv | 123 ++++++++++++
 tb/tb_maj_fold_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_fold_pkg.sv
// Shared types and helpers for the folded majority/threshold evaluator.
// Optional build macro MAJ_FOLD_EARLY_EXIT_EN is consumed by maj_fold_ctrl.
package maj_fold_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of chunks needed to cover n bits, c bits at a time.
    function automatic int nch(input int n, input int c);
        return (n + c - 1) / c;
    endfunction

    // Population count of up to 64 bits; callers zero-extend narrower vectors.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) s++;
        end
        return s;
    endfunction

endpackage

// File: rtl/maj_fold_ctrl_popcount.sv
// Combinational CHUNK-bit popcount: the single shared datapath slice.
module maj_chunk_popcount
    import maj_fold_pkg::*;
#(
    parameter int CHUNK = 4,
    parameter int PCW   = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] chunk_i,
    output logic [PCW-1:0]   cnt_o
);

    // Count set bits of the current chunk.
    always_comb begin
        cnt_o = PCW'(popcount(64'(chunk_i)));
    end

endmodule

// File: rtl/maj_fold_ctrl.sv
// Folded majority/threshold evaluator: scores an N-bit vector CHUNK bits per
// cycle and reports y0 = (popcount(x) >= THRESH).
// Build macro MAJ_FOLD_EARLY_EXIT_EN: leave ACCUM as soon as y0 is decided;
// count then reports the partial sum at the exit point.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// ACCUM | one chunk scored per edge
// DONE  | result presented until out_ready
module maj_fold_ctrl
    import maj_fold_pkg::*;
#(
    parameter int N      = 23,
    parameter int CHUNK  = 4,
    parameter int THRESH = (N / 2) + 1,
    parameter int CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          y0,
    output logic [CW-1:0] count,
    output logic          busy
);

    localparam int NCH = nch(N, CHUNK);
    localparam int SW  = NCH * CHUNK;
    localparam int PCW = $clog2(CHUNK + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t          state_q;
    logic [SW-1:0]   sreg_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   acc_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            y0_q;
    logic [CW-1:0]   count_q;

    logic [PCW-1:0]  pc;
    logic [CW-1:0]   acc_d;
    logic            hit_d;
    logic            finish_d;

    maj_chunk_popcount #(.CHUNK(CHUNK), .PCW(PCW)) u_pc (
        .chunk_i (sreg_q[CHUNK-1:0]),
        .cnt_o   (pc)
    );

    // Next accumulator value and the decision to leave ACCUM this edge.
    always_comb begin
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        int rem;
`endif
        acc_d    = acc_q + CW'(pc);
        hit_d    = int'(acc_d) >= THRESH;
        finish_d = (idx_q == IW'(NCH - 1));
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        // Bits still unscored after this chunk; pad bits are excluded.
        rem = N - (int'(idx_q) + 1) * CHUNK;
        if (rem < 0) rem = 0;
        if (hit_d || (int'(acc_d) + rem < THRESH)) finish_d = 1'b1;
`endif
    end

    // Controller FSM with shift register, chunk index, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y0_q        <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sreg_q     <= SW'(x);
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q  <= acc_d;
                    sreg_q <= sreg_q >> CHUNK;
                    idx_q  <= idx_q + IW'(1);
                    if (finish_d) begin
                        out_valid_q <= 1'b1;
                        y0_q        <= hit_d;
                        count_q     <= acc_d;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y0        = y0_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_maj_fold_ctrl.sv
// Directed + random bench for maj_fold_ctrl at N=23, CHUNK=4, THRESH=12.
// Honours MAJ_FOLD_EARLY_EXIT_EN when the design is built with it.
module tb_maj_fold_ctrl;
    import maj_fold_pkg::*;

    localparam int N      = 23;
    localparam int CHUNK  = 4;
    localparam int THRESH = 12;
    localparam int CW     = 5;
    localparam int NCH    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          y0;
    logic [CW-1:0] count;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    maj_fold_ctrl #(.N(N), .CHUNK(CHUNK), .THRESH(THRESH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] v;
        int           cnt;
        int           y;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: chunked scoring with optional early decision.
    function automatic void ref_model(input logic [N-1:0] v, output int cnt,
                                      output int y, output int lat);
        logic [23:0] s;
        int acc;
        int rem;
        s   = {1'b0, v};
        acc = 0;
        lat = NCH;
        for (int i = 0; i < NCH; i++) begin
            logic [3:0] c;
            c = s[i*4 +: 4];
            acc += int'(popcount(64'(c)));
            rem = N - (i + 1) * CHUNK;
            if (rem < 0) rem = 0;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
            if (acc >= THRESH || acc + rem < THRESH) begin
                lat = i + 1;
                break;
            end
`endif
        end
        cnt = acc;
        y   = (acc >= THRESH) ? 1 : 0;
    endfunction

    // Send one vector, wait for the result, optionally stall the handshake.
    task automatic send(input logic [N-1:0] v, input int stall, input bit poke,
                        input string tag, output int y_o, output int c_o, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check({tag, " in_ready timeout"}, 0, 1);
        x = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = N'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y_o = int'(y0);
        c_o = int'(count);
        if (poke) begin
            in_valid = 1'b1;
            x = '1;
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (poke) begin
                check({tag, " stall out_valid"}, int'(out_valid), 1);
                check({tag, " stall y0"}, int'(y0), y_o);
                check({tag, " stall count"}, int'(count), c_o);
                check({tag, " stall in_ready"}, int'(in_ready), 0);
                check({tag, " stall busy"}, int'(busy), 1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        if (poke) begin
            check({tag, " post out_valid"}, int'(out_valid), 0);
            check({tag, " post not accepted"}, int'(busy), 0);
            check({tag, " post in_ready"}, int'(in_ready), 1);
        end
    endtask

    vec_t tbl[9];

    initial begin
        int y, c, lat, ey, ec, el, g;

        tbl[0] = '{23'h000000,  0, 0};
        tbl[1] = '{23'h000FFF, 12, 1};
        tbl[2] = '{23'h0007FF, 11, 0};
        tbl[3] = '{23'h7FFFFF, 23, 1};
        tbl[4] = '{23'h7FF000, 11, 0};
        tbl[5] = '{23'h555555, 12, 1};
        tbl[6] = '{23'h2AAAAA, 11, 0};
        tbl[7] = '{23'h400001,  2, 0};
        tbl[8] = '{23'h7FFFFE, 22, 1};

        // Reset state
        #12;
        check("rst in_ready", int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst y0", int'(y0), 0);
        check("rst count", int'(count), 0);
        check("rst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].v, 0, 1'b0, "tbl", y, c, lat);
            ec = tbl[i].cnt;
            ey = tbl[i].y;
            el = NCH;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
            ref_model(tbl[i].v, ec, ey, el);
`endif
            check($sformatf("tbl[%0d] y0", i), y, ey);
            check($sformatf("tbl[%0d] count", i), c, ec);
            check($sformatf("tbl[%0d] latency", i), lat, el);
        end

        // Stall in DONE with a pending in_valid
        send(23'h000FFF, 5, 1'b1, "stall", y, c, lat);
        check("stall y0", y, 1);
        check("stall count", c, 12);

        // Reset mid-ACCUM at idx=3
        send(23'h7FFFFF, 0, 1'b0, "pre", y, c, lat);
        @(negedge clk);
        x = 23'h0000FF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid busy", int'(busy), 1);
        check("mid in_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("arst in_ready", int'(in_ready), 1);
        check("arst out_valid", int'(out_valid), 0);
        check("arst count", int'(count), 0);
        check("arst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        g = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) g++;
        end
        check("arst no result", g, 0);
        send(23'h555555, 0, 1'b0, "after", y, c, lat);
        ref_model(23'h555555, ec, ey, el);
        check("after y0", y, 1);
        check("after count", c, ec);

`ifdef MAJ_FOLD_EARLY_EXIT_EN
        send(23'h000FFF, 0, 1'b0, "ee1", y, c, lat);
        check("ee1 latency", lat, 3);
        check("ee1 y0", y, 1);
        check("ee1 count", c, 12);
        send(23'h7FF000, 0, 1'b0, "ee2", y, c, lat);
        check("ee2 latency", lat, 3);
        check("ee2 y0", y, 0);
        check("ee2 count", c, 0);
`endif

        // Random vectors with random stalls
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] v;
            case (i % 4)
                0: v = N'($urandom);
                1: v = N'($urandom) & N'($urandom);
                2: v = N'($urandom) | N'($urandom);
                default: v = N'($urandom) ^ (N'($urandom) & N'($urandom));
            endcase
            send(v, $urandom_range(0, 3), 1'b0, "rnd", y, c, lat);
            ref_model(v, ec, ey, el);
            check("rnd y0", y, ey);
            check("rnd count", c, ec);
            check("rnd latency", lat, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
